// File: rtl/dac_tx_pkg.sv
// Shared definitions for the serial DAC playback engine: FSM states, frame
// constants and small helpers for the length clamp and the period reload.
package dac_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SYNC  = 3'd3,
        SHIFT = 3'd4,
        LATCH = 3'd5,
        WAIT  = 3'd6
    } state_t;

    localparam int FRAME_CYCLES = 20;
    localparam int SAMPLE_BITS  = 16;
    localparam int MAX_LEN      = 1024;

    // Requested pass lengths beyond the buffer size play the whole buffer.
    function automatic logic [10:0] clamp_len(input logic [11:0] len);
        if (len > 12'(MAX_LEN)) begin
            clamp_len = 11'(MAX_LEN);
        end else begin
            clamp_len = len[10:0];
        end
    endfunction

    // A period of 0 would underflow; it behaves like any other short period.
    function automatic logic [15:0] period_load(input logic [15:0] p);
        if (p == 16'd0) begin
            period_load = 16'd0;
        end else begin
            period_load = p - 16'd1;
        end
    endfunction

endpackage

// File: rtl/dac_serial_tx.sv
// Serial DAC playback engine: reads samples from the playback RAM and shifts
// each one MSB-first over SYNC_N/SCLK/DIN, one frame per programmed period.
module dac_serial_tx
    import dac_tx_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_sd,
    input  logic                  OPB_RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  loop_en,
    input  logic [11:0]           data_length,
    input  logic [15:0]           period,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  DAC_SYNC_N,
    output logic                  DAC_SCLK_EN,
    output logic                  DAC_DIN,
    output logic                  busy,
    output logic                  done,
    output logic [10:0]           sample_count,
    output logic                  period_err
);

    localparam int             BW      = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0]  BIT_TOP = BW'(DATA_WIDTH - 1);

    state_t                  state_r;
    logic [15:0]             period_cnt_r;
    logic [15:0]             period_r;
    logic [10:0]             len_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [BW-1:0]           bit_cnt_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [10:0]             count_r;
    logic                    sync_n_r;
    logic                    sclk_en_r;
    logic                    din_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    period_err_r;

    logic [10:0]             len_in_s;
    logic                    last_s;
    logic                    expired_s;
    logic                    wrap_s;

    // Decode of the pass-end, period-expiry and loop-wrap conditions.
    always_comb begin
        len_in_s  = clamp_len(data_length);
        last_s    = ((count_r + 11'd1) == len_r);
        expired_s = (period_cnt_r == 16'd0);
        if (loop_en && (len_in_s != 11'd0)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Playback FSM with registered DAC, RAM and status outputs.
    always_ff @(posedge clk_sd or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_r      <= IDLE;
            period_cnt_r <= 16'd0;
            period_r     <= 16'd0;
            len_r        <= 11'd0;
            shift_r      <= '0;
            bit_cnt_r    <= '0;
            addr_r       <= '0;
            count_r      <= 11'd0;
            sync_n_r     <= 1'b1;
            sclk_en_r    <= 1'b0;
            din_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            period_err_r <= 1'b0;
        end else if (abort) begin
            state_r      <= IDLE;
            period_cnt_r <= 16'd0;
            bit_cnt_r    <= '0;
            addr_r       <= '0;
            count_r      <= 11'd0;
            sync_n_r     <= 1'b1;
            sclk_en_r    <= 1'b0;
            din_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            // The frame timer free-runs down to zero and is reloaded on FETCH entry.
            period_cnt_r <= expired_s ? 16'd0 : (period_cnt_r - 16'd1);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        done_r       <= 1'b0;
                        period_err_r <= 1'b0;
                        len_r        <= len_in_s;
                        period_r     <= period;
                        addr_r       <= '0;
                        count_r      <= 11'd0;
                        if (len_in_s == 11'd0) begin
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end else begin
                            busy_r       <= 1'b1;
                            state_r      <= FETCH;
                            period_cnt_r <= period_load(period);
                        end
                    end
                end
                FETCH: begin
                    if (period_r < 16'(FRAME_CYCLES)) begin
                        period_err_r <= 1'b1;
                    end
                    state_r <= LOAD;
                end
                LOAD: begin
                    shift_r  <= ram_rd_data;
                    din_r    <= ram_rd_data[DATA_WIDTH-1];
                    sync_n_r <= 1'b0;
                    state_r  <= SYNC;
                end
                SYNC: begin
                    sclk_en_r <= 1'b1;
                    bit_cnt_r <= BIT_TOP;
                    state_r   <= SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt_r == '0) begin
                        sclk_en_r <= 1'b0;
                        sync_n_r  <= 1'b1;
                        din_r     <= 1'b0;
                        state_r   <= LATCH;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - BW'(1);
                        shift_r   <= {shift_r[DATA_WIDTH-2:0], 1'b0};
                        din_r     <= shift_r[DATA_WIDTH-2];
                    end
                end
                LATCH: begin
                    if (last_s) begin
                        addr_r <= '0;
                        if (wrap_s) begin
                            // New pass: length and period are re-sampled at the wrap.
                            count_r  <= 11'd0;
                            len_r    <= len_in_s;
                            period_r <= period;
                            if (expired_s) begin
                                state_r      <= FETCH;
                                period_cnt_r <= period_load(period);
                            end else begin
                                state_r <= WAIT;
                            end
                        end else begin
                            count_r <= count_r + 11'd1;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else begin
                        addr_r  <= addr_r + ADDR_WIDTH'(1);
                        count_r <= count_r + 11'd1;
                        if (expired_s) begin
                            state_r      <= FETCH;
                            period_cnt_r <= period_load(period_r);
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (expired_s) begin
                        state_r      <= FETCH;
                        period_cnt_r <= period_load(period_r);
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ram_addr     = addr_r;
    assign DAC_SYNC_N   = sync_n_r;
    assign DAC_SCLK_EN  = sclk_en_r;
    assign DAC_DIN      = din_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign sample_count = count_r;
    assign period_err   = period_err_r;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Self-checking bench for dac_serial_tx: a DAC receiver model decodes frames
// from the serial pins and results are compared with expectations from RAM.
`timescale 1ns/1ps
module tb_dac_serial_tx;

    logic        clk_sd = 1'b0;
    logic        OPB_RST;
    logic        start;
    logic        abort;
    logic        loop_en;
    logic [11:0] data_length;
    logic [15:0] period;
    logic [9:0]  ram_addr;
    logic [15:0] ram_rd_data;
    logic        DAC_SYNC_N;
    logic        DAC_SCLK_EN;
    logic        DAC_DIN;
    logic        busy;
    logic        done;
    logic [10:0] sample_count;
    logic        period_err;

    logic [15:0] mem [0:1023];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    logic        prev_sync    = 1'b1;
    logic [15:0] word_acc     = 16'd0;
    int          bits         = 0;
    int          last_partial = -1;
    logic [15:0] words[$];
    int          falls[$];
    int          fall_cnt[$];
    int          fall_addr[$];

    dac_serial_tx #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
        .clk_sd       (clk_sd),
        .OPB_RST      (OPB_RST),
        .start        (start),
        .abort        (abort),
        .loop_en      (loop_en),
        .data_length  (data_length),
        .period       (period),
        .ram_addr     (ram_addr),
        .ram_rd_data  (ram_rd_data),
        .DAC_SYNC_N   (DAC_SYNC_N),
        .DAC_SCLK_EN  (DAC_SCLK_EN),
        .DAC_DIN      (DAC_DIN),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .period_err   (period_err)
    );

    always #5 clk_sd = ~clk_sd;

    always @(posedge clk_sd) ram_rd_data <= mem[ram_addr];
    always @(posedge clk_sd) cyc <= cyc + 1;

    // DAC receiver: samples DIN on each SCLK falling edge inside a SYNC_N frame.
    always @(negedge clk_sd) begin
        if (prev_sync === 1'b1 && DAC_SYNC_N === 1'b0) begin
            falls.push_back(cyc);
            fall_cnt.push_back(int'(sample_count));
            fall_addr.push_back(int'(ram_addr));
            bits     <= 0;
            word_acc <= 16'd0;
        end else if (DAC_SYNC_N === 1'b0 && DAC_SCLK_EN === 1'b1) begin
            word_acc <= {word_acc[14:0], DAC_DIN};
            bits     <= bits + 1;
        end else if (prev_sync === 1'b0 && DAC_SYNC_N === 1'b1) begin
            if (bits == 16) words.push_back(word_acc);
            else last_partial <= bits;
        end
        prev_sync <= DAC_SYNC_N;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sd);
        #1;
    endtask

    task automatic clear_mon();
        words.delete();
        falls.delete();
        fall_cnt.delete();
        fall_addr.delete();
        last_partial = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    function automatic int spacing(input int p);
        return (p < 20) ? 20 : p;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy === 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_finished"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_falls(input string tag, input int n, input int budget);
        int k = 0;
        while (falls.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_frames_seen"}, 32'(falls.size() >= n), 32'd1);
    endtask

    task automatic wait_sclk(input string tag, input int budget);
        int k = 0;
        while (DAC_SCLK_EN !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_sclk_seen"}, 32'(DAC_SCLK_EN), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sync_n"},  32'(DAC_SYNC_N),   32'd1);
        check({tag, "_sclk_en"}, 32'(DAC_SCLK_EN),  32'd0);
        check({tag, "_din"},     32'(DAC_DIN),      32'd0);
        check({tag, "_busy"},    32'(busy),         32'd0);
        check({tag, "_done"},    32'(done),         32'd0);
        check({tag, "_addr"},    32'(ram_addr),     32'd0);
        check({tag, "_count"},   32'(sample_count), 32'd0);
    endtask

    // One non-looping pass, checked against the RAM image and frame timing rules.
    task automatic run_pass(input string tag, input int len, input int per);
        int s0, eff, n;
        clear_mon();
        loop_en     = 1'b0;
        data_length = 12'(len);
        period      = 16'(per);
        pulse_start();
        s0  = cyc;
        eff = (len > 1024) ? 1024 : len;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        wait_idle(tag, eff * spacing(per) + 100);
        check({tag, "_frames"}, 32'(words.size()), 32'(eff));
        n = (words.size() < eff) ? words.size() : eff;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", tag, i), 32'(words[i]), 32'(mem[i]));
            check($sformatf("%s_addr%0d", tag, i), 32'(fall_addr[i]), 32'(i));
        end
        if (falls.size() > 0) begin
            check({tag, "_first_sync"}, 32'(falls[0]), 32'(s0 + 2));
            check({tag, "_busy_fall"}, 32'(cyc), 32'(falls[falls.size() - 1] + 18));
        end
        for (int i = 1; i < falls.size(); i++) begin
            check($sformatf("%s_gap%0d", tag, i), 32'(falls[i] - falls[i-1]), 32'(spacing(per)));
        end
        check({tag, "_done"},   32'(done),         32'd1);
        check({tag, "_addr0"},  32'(ram_addr),     32'd0);
        check({tag, "_count"},  32'(sample_count), 32'(eff));
        check({tag, "_perr"},   32'(period_err),   32'(per < 20));
    endtask

    initial begin
        OPB_RST     = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        loop_en     = 1'b0;
        data_length = 12'd0;
        period      = 16'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        tick(3);
        check_idle_outputs("reset");
        check("reset_perr", 32'(period_err), 32'd0);
        @(negedge clk_sd);
        OPB_RST = 1'b0;
        tick(2);

        // Directed single pass from the test plan.
        mem[0] = 16'hA5A5;
        mem[1] = 16'h0001;
        mem[2] = 16'hFFFF;
        run_pass("single", 3, 50);

        // Periods shorter than a frame run back to back.
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        run_pass("short", 4, int'($urandom_range(0, 19)));

        // Random lengths and periods.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
            run_pass($sformatf("rnd%0d", t), int'($urandom_range(1, 6)), int'($urandom_range(20, 64)));
        end

        // Loop mode over two samples.
        clear_mon();
        loop_en     = 1'b1;
        data_length = 12'd2;
        period      = 16'd30;
        pulse_start();
        wait_falls("loop", 5, 400);
        check("loop_done_low", 32'(done), 32'd0);
        check("loop_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick(1);
        abort   = 1'b0;
        loop_en = 1'b0;
        for (int k = 0; k < 4 && k < words.size(); k++) begin
            check($sformatf("loop_word%0d", k), 32'(words[k]), 32'(mem[k % 2]));
            check($sformatf("loop_count%0d", k), 32'(fall_cnt[k]), 32'(k % 2));
        end
        for (int k = 1; k < 5 && k < falls.size(); k++) begin
            check($sformatf("loop_gap%0d", k), 32'(falls[k] - falls[k-1]), 32'd30);
        end
        check_idle_outputs("loop_abort");

        // Abort mid-SHIFT after 7 bits.
        clear_mon();
        data_length = 12'd3;
        period      = 16'd40;
        pulse_start();
        wait_sclk("abort", 40);
        tick(6);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_idle_outputs("abort");
        tick(2);
        check("abort_partial_bits", 32'(last_partial), 32'd7);
        check("abort_no_word", 32'(words.size()), 32'd0);

        // Empty pass.
        clear_mon();
        data_length = 12'd0;
        pulse_start();
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd0);
        tick(30);
        check("empty_no_sync", 32'(falls.size()), 32'd0);

        // Replay after abort starts again at RAM[0].
        run_pass("replay", 3, 40);

        // Oversized length clamps to the full buffer.
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        run_pass("big", 2000, int'($urandom_range(0, 20)));

        // Asynchronous reset mid-frame.
        clear_mon();
        data_length = 12'd3;
        period      = 16'd40;
        pulse_start();
        wait_sclk("rst", 40);
        #3;
        OPB_RST = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        check("async_rst_perr", 32'(period_err), 32'd0);
        @(negedge clk_sd);
        OPB_RST = 1'b0;
        tick(2);

        // start and abort together: abort wins.
        clear_mon();
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        check("both_busy", 32'(busy), 32'd0);
        tick(30);
        check("both_no_sync", 32'(falls.size()), 32'd0);
        check("both_done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_serial_tx.md
# dac_serial_tx

Serial DAC playback engine, the transmit counterpart of the ADS8864 capture path. It reads 16-bit samples from the playback sample RAM and shifts each one MSB-first to a 3-wire SPI DAC (SYNC_N/SCLK/DIN), one frame per programmable sample period. It runs entirely in the `clk_sd` domain; the OPB register file and the RAM write port sit outside it.

## Interface
Parameters:
- ADDR_WIDTH, 10: sample RAM address width (1024 samples).
- DATA_WIDTH, 16: sample width; also the number of bits shifted per frame.

Ports:
- clk_sd  in  1  serial clock (external CLOCK_DIV output); all logic on its rising edge.
- OPB_RST  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to start playback, already synchronised to clk_sd.
- abort  in  1  one-cycle request to stop immediately, already synchronised to clk_sd.
- loop_en  in  1  1 = replay the buffer continuously.
- data_length  in  12  samples per pass; 0 = empty pass; values above 1024 are clamped to 1024.
- period  in  16  clk_sd cycles from one frame start to the next.
- ram_addr  out  ADDR_WIDTH  sample RAM read address.
- ram_rd_data  in  DATA_WIDTH  sample RAM data, valid 1 cycle after ram_addr.
- DAC_SYNC_N  out  1  frame select, active-low.
- DAC_SCLK_EN  out  1  gate for DAC_SCLK = clk_sd & DAC_SCLK_EN (the AND is done at the top level).
- DAC_DIN  out  1  serial data, MSB first.
- busy  out  1  playback in progress.
- done  out  1  sticky; the last pass completed.
- sample_count  out  11  samples sent in the current pass.
- period_err  out  1  sticky; period < FRAME_CYCLES was in effect during a frame.

## Operation
- Reset values: DAC_SYNC_N=1, DAC_SCLK_EN=0, DAC_DIN=0, ram_addr=0, busy=0, done=0, sample_count=0, period_err=0, state IDLE.
- IDLE: on start, clear done and period_err and set busy.
  - If the effective length is 0, set done, clear busy and stay in IDLE.
  - Otherwise go to FETCH.
- FETCH: ram_addr holds the current pointer. Load period_cnt with period-1. Go to LOAD.
- LOAD: capture ram_rd_data into shift_reg. Go to SYNC.
- SYNC: DAC_SYNC_N=0. DAC_DIN=shift_reg[15]. DAC_SCLK_EN=1. Go to SHIFT.
- SHIFT, 16 cycles, bit_cnt 15 down to 0:
  - DAC_DIN presents shift_reg bits 15..0, one per cycle; the DAC samples on the SCLK falling edge, mid-cycle.
  - On the cycle that bit_cnt reaches 0, drop DAC_SCLK_EN. Go to LATCH.
- LATCH: DAC_SYNC_N=1 (the rising edge latches the DAC). Increment sample_count and ram_addr.
  - If sample_count+1 equals the effective length:
    - loop_en=1: ram_addr and sample_count go to 0, then WAIT.
    - loop_en=0: clear busy, set done, go to IDLE. ram_addr returns to 0.
  - Otherwise go to WAIT.
- WAIT: period_cnt decrements every cycle from FETCH onward. Go to FETCH when period_cnt is 0 or has already expired.
- Period check: if period < FRAME_CYCLES (20), frames run back-to-back at 20 cycles and period_err is set.
- abort, in any state: next cycle DAC_SYNC_N=1, DAC_SCLK_EN=0, DAC_DIN=0, busy=0, done=0, ram_addr=0, sample_count=0, state IDLE. A partial frame is discarded by the DAC because SYNC_N rises early.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- data_length and period are sampled at start and held until the pass ends. In loop mode they are re-sampled at each wrap.

## Timing
- Frame cost is 20 cycles: FETCH 1, LOAD 1, SYNC 1, SHIFT 16, LATCH 1.
- FETCH-to-FETCH spacing is max(period, 20).
- The first FETCH occurs 1 cycle after the start cycle.
- DAC_SYNC_N is low for 17 cycles per frame: SYNC plus 16 SHIFT cycles.
- DAC_SCLK_EN is high for the 16 SHIFT cycles only, giving exactly 16 falling edges per frame.
- done and the busy fall are visible 1 cycle after the last LATCH.
- RAM read latency is 1 cycle and is fixed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package dac_tx_pkg holds:
  - state enum: IDLE, FETCH, LOAD, SYNC, SHIFT, LATCH, WAIT.
  - FRAME_CYCLES=20, SAMPLE_BITS=16, MAX_LEN=1024.
- Single module, no sub-module. The top level owns the DP RAM, the OPB registers and the clk_sd divider.

## Test plan
- Single pass: RAM[0..2]=0xA5A5,0x0001,0xFFFF; data_length=3, period=50, start. Required:
  - DIN decodes 0xA5A5, 0x0001, 0xFFFF on SCLK falling edges.
  - SYNC_N falls are 50 cycles apart.
  - done=1, busy=0, ram_addr=0 after the 3rd LATCH.
- Short period: period=5, data_length=4. Required: frames 20 cycles apart, period_err=1, 4 frames of 16 bits each.
- Loop: loop_en=1, data_length=2, period=30. Required:
  - Sample sequence RAM[0], RAM[1], RAM[0], RAM[1]...
  - done stays 0; sample_count wraps 0→1→0.
- Abort mid-SHIFT after 7 bits. Required:
  - Next cycle SYNC_N=1 and SCLK_EN=0; busy=0, done=0, ram_addr=0.
  - A new start replays from RAM[0].
- Boundaries:
  - data_length=0 → done=1 the cycle after start, SYNC_N never falls.
  - data_length=2000 → exactly 1024 frames, addresses 0..1023.
- OPB_RST asserted mid-frame → all outputs return to reset values immediately (asynchronous); start+abort in the same cycle → stays IDLE.
